uart_reg_responder: RTL and testbench
=====================================

Name: uart_reg_responder

Overview:
- Byte-protocol responder between the uart block's receiver/transmitter byte ports and a small parallel register bus.
- A host sends command frames over the serial line. The block decodes each frame, performs a single register read or write on the bus, and returns a reply byte through the transmitter.
- It runs on the same 50 MHz clock as uart and is instantiated beside it at the top level.

Parameters:
- TIMEOUT_CYCLES, 50000, maximum clocks allowed between frame bytes before the partial frame is discarded (1 ms at 50 MHz).
- ACK_BYTE, 8'h55, reply byte for a successful write.
- NAK_BYTE, 8'hEE, reply byte for a malformed or rejected frame.

Ports:
- clk_50m  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte from uart dout.
- rx_rdy  in  1  level flag from uart rdy; high while a byte is pending.
- rx_rdy_clr  out  1  one-cycle pulse that clears rx_rdy.
- tx_din  out  8  byte to transmit; held stable from the wr_en pulse until tx_busy falls.
- tx_wr_en  out  1  one-cycle pulse that starts transmission.
- tx_busy  in  1  transmitter busy; rises the cycle after tx_wr_en.
- bus_addr  out  4  register address.
- bus_wdata  out  8  write data.
- bus_we  out  1  one-cycle write strobe.
- bus_re  out  1  one-cycle read strobe.
- bus_rdata  in  8  read data, valid the cycle after bus_re.
- overrun  out  1  sticky flag: a byte arrived while the block was not accepting bytes.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE. All outputs are 0, including tx_din, bus_addr, bus_wdata and overrun; the timeout counter is 0. A reset in mid-frame drops the frame. A reset during transmission stops further wr_en pulses; the transmitter may still finish its current byte, which the block ignores.
- Byte accept: a byte is accepted on a rising edge of rx_rdy (registered previous value). On that edge the block captures rx_data and pulses rx_rdy_clr in the same cycle. A level that stays high is never double-counted.
- Command byte format:
  - bit7 = 1 write, 0 read.
  - bits6:4 must be 000; any other value makes the frame invalid.
  - bits3:0 = address.
- States:
  - IDLE: on a byte, if invalid go to SEND with NAK_BYTE. A read goes to BUS_RD, asserting bus_re and bus_addr. A write latches the address and goes to WAIT_DATA.
  - WAIT_DATA: on a byte, pulse bus_we with bus_wdata = byte, then go to SEND with ACK_BYTE. When the timeout counter reaches TIMEOUT_CYCLES-1, go to IDLE with no reply.
  - BUS_RD: one cycle; latch bus_rdata into tx_din and go to SEND.
  - SEND: pulse tx_wr_en when tx_busy=0, then go to WAIT_BUSY.
  - WAIT_BUSY: wait for tx_busy=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for tx_busy=0, then go to IDLE (or to the next queued reply byte).
- Timeout counter: cleared on every accepted byte and whenever leaving WAIT_DATA; counts in WAIT_DATA only; saturates, never wraps.
- Overrun: an rx_rdy rising edge in BUS_RD, SEND, WAIT_BUSY or WAIT_DONE sets overrun. The block still pulses rx_rdy_clr and discards the byte. overrun clears only on rst.
- Simultaneous events: a byte edge in the same cycle as a timeout is accepted as data, i.e. the byte wins.
- Strobes: bus_we and bus_re each last exactly one cycle and are never asserted together.

Optional Feature:
- Macro: UART_RSP_CHECKSUM_EN.
- When defined:
  - A write frame takes three bytes; the third is a checksum equal to cmd XOR data (adds state WAIT_CSUM, same timeout rule).
  - On mismatch, reply NAK_BYTE and do not pulse bus_we.
  - A read reply is two bytes: rdata, then cmd XOR rdata, sent back-to-back through SEND/WAIT_BUSY/WAIT_DONE.
- When undefined: two-byte writes and a one-byte read reply; no WAIT_CSUM state.

Decomposition:
- Shared package holds:
  - state enumeration constants.
  - command field positions (RW bit 7, reserved bits 6:4, address bits 3:0).
  - default ACK/NAK byte values.
- Natural sub-module: uart_tx_sender, the SEND/WAIT_BUSY/WAIT_DONE handshake with the transmitter, with start/done ports. The top FSM handles frame decoding.

Test Plan:
- Write: bytes 8'h83, 8'hA5 → single bus_we with addr 3 and wdata A5; tx_din=55 with exactly one tx_wr_en pulse; busy falls after tx_busy falls.
- Read: byte 8'h07 with bus_rdata=8'h3C → one bus_re with addr 7; reply byte 3C; no bus_we.
- Invalid command 8'h90 → reply EE; no bus strobes.
- Timeout: byte 8'h81, then silence for 50000 cycles → return to IDLE with no reply. A following 8'h02 read is handled normally.
- Overrun and reset:
  - Send a byte while tx_busy=1 → overrun=1, byte dropped, rx_rdy_clr pulsed.
  - Assert rst mid-WAIT_DATA → all outputs 0 immediately; overrun cleared.
- With UART_RSP_CHECKSUM_EN: frame 8'h81, 8'h10, 8'h91 → write performed, reply 55. Checksum byte 8'h00 instead → no write, reply EE.

Source files
------------

// File: rtl/uart_reg_responder_pkg.sv
// Shared types and constants for the UART register responder.
// Optional feature macro: UART_RSP_CHECKSUM_EN (adds the WAIT_CSUM state).
`timescale 1ns/1ps
package uart_reg_responder_pkg;

  // Frame-decoding states of the top FSM; SEND covers the whole transmitter handshake.
  typedef enum logic [2:0] {
    StIdle,
    StWaitData,
`ifdef UART_RSP_CHECKSUM_EN
    StWaitCsum,
`endif
    StBusRd,
    StSend
  } rsp_state_e;

  // Transmitter handshake states.
  typedef enum logic [1:0] {
    SndIdle,
    SndSend,
    SndWaitBusy,
    SndWaitDone
  } snd_state_e;

  // Command byte fields.
  localparam int unsigned CMD_RW_BIT  = 7;
  localparam int unsigned CMD_RSVD_HI = 6;
  localparam int unsigned CMD_RSVD_LO = 4;
  localparam int unsigned CMD_ADDR_HI = 3;
  localparam int unsigned CMD_ADDR_LO = 0;

  localparam logic [7:0] ACK_DEFAULT = 8'h55;
  localparam logic [7:0] NAK_DEFAULT = 8'hEE;

  // A command is well formed only when its reserved bits are all zero.
  function automatic logic cmd_valid(logic [7:0] cmd);
    return cmd[CMD_RSVD_HI:CMD_RSVD_LO] == 3'b000;
  endfunction

endpackage

// File: rtl/uart_reg_responder_tx_sender.sv
// Transmitter handshake: wait for idle, pulse wr_en, wait for busy to rise and then fall.
`timescale 1ns/1ps
module uart_tx_sender
  import uart_reg_responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       tx_busy,
  output logic [7:0] tx_din,
  output logic       tx_wr_en,
  output logic       done
);

  snd_state_e state_q, state_d;
  logic [7:0] din_q;

  // State register and reply byte, held stable for the whole transmission.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SndIdle;
      din_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      if (start && (state_q == SndIdle)) din_q <= byte_in;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d  = state_q;
    tx_wr_en = 1'b0;
    done     = 1'b0;
    case (state_q)
      SndIdle: if (start) state_d = SndSend;
      SndSend: begin
        if (!tx_busy) begin
          tx_wr_en = 1'b1;
          state_d  = SndWaitBusy;
        end
      end
      SndWaitBusy: if (tx_busy) state_d = SndWaitDone;
      SndWaitDone: begin
        if (!tx_busy) begin
          done    = 1'b1;
          state_d = SndIdle;
        end
      end
      default: state_d = SndIdle;
    endcase
  end

  assign tx_din = din_q;

endmodule

// File: rtl/uart_reg_responder.sv
// Frame decoder between the UART byte ports and a small register bus.
// Optional feature macro: UART_RSP_CHECKSUM_EN (checksummed writes, two-byte read reply).
`timescale 1ns/1ps
module uart_reg_responder
  import uart_reg_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  ACK_BYTE       = ACK_DEFAULT,
  parameter logic [7:0]  NAK_BYTE       = NAK_DEFAULT
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_rdy,
  output logic       rx_rdy_clr,
  output logic [7:0] tx_din,
  output logic       tx_wr_en,
  input  logic       tx_busy,
  output logic [3:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_we,
  output logic       bus_re,
  input  logic [7:0] bus_rdata,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CntW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);

  rsp_state_e      state_q, state_d;
  logic            rx_rdy_q;
  logic [3:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            we_q, we_d, re_q, re_d;
  logic            overrun_q, overrun_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            start_q, start_d;
  logic            sel_rd_q, sel_rd_d;   // reply comes straight from bus_rdata
  logic [7:0]      reply_q, reply_d;
  logic            byte_edge, tmo, send_done;
  logic [7:0]      send_byte;
`ifdef UART_RSP_CHECKSUM_EN
  logic [7:0]      cmd_q, cmd_d;
  logic            second_q, second_d;   // checksum reply byte still owed
`endif

  assign byte_edge = rx_rdy & ~rx_rdy_q;
  assign tmo       = (cnt_q == TmoLast);
  assign send_byte = sel_rd_q ? bus_rdata : reply_q;

  // State and datapath registers.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rx_rdy_q  <= 1'b0;
      addr_q    <= 4'h0;
      wdata_q   <= 8'h00;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      overrun_q <= 1'b0;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      sel_rd_q  <= 1'b0;
      reply_q   <= 8'h00;
`ifdef UART_RSP_CHECKSUM_EN
      cmd_q     <= 8'h00;
      second_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rx_rdy_q  <= rx_rdy;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      overrun_q <= overrun_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      sel_rd_q  <= sel_rd_d;
      reply_q   <= reply_d;
`ifdef UART_RSP_CHECKSUM_EN
      cmd_q     <= cmd_d;
      second_q  <= second_d;
`endif
    end
  end

  // Frame decoding, bus strobes, timeout and overrun.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    overrun_d = overrun_q;
    cnt_d     = '0;
    start_d   = 1'b0;
    sel_rd_d  = sel_rd_q;
    reply_d   = reply_q;
`ifdef UART_RSP_CHECKSUM_EN
    cmd_d     = cmd_q;
    second_d  = second_q;
`endif
    case (state_q)
      StIdle: begin
        if (byte_edge) begin
`ifdef UART_RSP_CHECKSUM_EN
          cmd_d = rx_data;
`endif
          addr_d = rx_data[CMD_ADDR_HI:CMD_ADDR_LO];
          if (!cmd_valid(rx_data)) begin
            reply_d  = NAK_BYTE;
            sel_rd_d = 1'b0;
            start_d  = 1'b1;
            state_d  = StSend;
          end else if (rx_data[CMD_RW_BIT]) begin
            state_d = StWaitData;
          end else begin
            re_d    = 1'b1;
            state_d = StBusRd;
          end
        end
      end
      StWaitData: begin
        // A byte arriving on the timeout cycle is still taken as data.
        if (byte_edge) begin
          wdata_d = rx_data;
`ifdef UART_RSP_CHECKSUM_EN
          state_d = StWaitCsum;
`else
          we_d     = 1'b1;
          reply_d  = ACK_BYTE;
          sel_rd_d = 1'b0;
          start_d  = 1'b1;
          state_d  = StSend;
`endif
        end else if (tmo) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`ifdef UART_RSP_CHECKSUM_EN
      StWaitCsum: begin
        if (byte_edge) begin
          if (rx_data == (cmd_q ^ wdata_q)) begin
            we_d    = 1'b1;
            reply_d = ACK_BYTE;
          end else begin
            reply_d = NAK_BYTE;
          end
          sel_rd_d = 1'b0;
          start_d  = 1'b1;
          state_d  = StSend;
        end else if (tmo) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif
      StBusRd: begin
        // bus_rdata is valid on the cycle start_q is high, when the sender samples it.
        sel_rd_d = 1'b1;
        start_d  = 1'b1;
        state_d  = StSend;
`ifdef UART_RSP_CHECKSUM_EN
        second_d = 1'b1;
`endif
      end
      StSend: begin
        if (send_done) begin
`ifdef UART_RSP_CHECKSUM_EN
          if (second_q) begin
            second_d = 1'b0;
            sel_rd_d = 1'b0;
            start_d  = 1'b1;
          end else begin
            state_d = StIdle;
          end
`else
          state_d = StIdle;
`endif
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef UART_RSP_CHECKSUM_EN
    if (start_q && sel_rd_q) reply_d = cmd_q ^ bus_rdata;
`endif

    if (byte_edge && ((state_q == StBusRd) || (state_q == StSend))) overrun_d = 1'b1;
  end

  uart_tx_sender u_sender (
    .clk      (clk_50m),
    .rst      (rst),
    .start    (start_q),
    .byte_in  (send_byte),
    .tx_busy  (tx_busy),
    .tx_din   (tx_din),
    .tx_wr_en (tx_wr_en),
    .done     (send_done)
  );

  assign rx_rdy_clr = byte_edge & ~rst;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign bus_we     = we_q;
  assign bus_re     = re_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_reg_responder.sv
// Self-checking bench for uart_reg_responder: vector table plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_uart_reg_responder;

  localparam int TxLen = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_rdy = 1'b0;
  logic       rx_rdy_clr;
  logic [7:0] tx_din;
  logic       tx_wr_en;
  logic       tx_busy = 1'b0;
  logic [3:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_re;
  logic [7:0] bus_rdata = 8'h00;
  logic       overrun;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int we_cnt = 0, re_cnt = 0, wr_cnt = 0;
  int tx_left = 0;
  bit tx_pend = 1'b0;

  logic [7:0]  exp_tx[$];
  logic [12:0] exp_bus[$];   // {we, addr, wdata-or-zero}

  uart_reg_responder dut (
    .clk_50m    (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_rdy     (rx_rdy),
    .rx_rdy_clr (rx_rdy_clr),
    .tx_din     (tx_din),
    .tx_wr_en   (tx_wr_en),
    .tx_busy    (tx_busy),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_we     (bus_we),
    .bus_re     (bus_re),
    .bus_rdata  (bus_rdata),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  function automatic void check(string name, logic [31:0] got, logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endfunction

  // Bus/transmit scoreboard and a simple transmitter model, all sampled on the falling edge.
  always @(negedge clk) begin
    if (bus_we && bus_re) begin
      fails++;
      $display("FAIL strobe_overlap: got we=1 re=1, want at most one");
    end
    if (bus_we || bus_re) begin
      if (bus_we) we_cnt++;
      else re_cnt++;
      if (exp_bus.size() == 0) begin
        fails++;
        $display("FAIL bus_unexpected: got we=%0d addr=%0h, want no strobe", bus_we, bus_addr);
      end else begin
        check("bus_txn", {19'd0, bus_we, bus_addr, (bus_we ? bus_wdata : 8'h00)},
              {19'd0, exp_bus.pop_front()});
      end
    end
    if (tx_wr_en) begin
      wr_cnt++;
      if (exp_tx.size() == 0) begin
        fails++;
        $display("FAIL tx_unexpected: got byte %0h, want no transmission", tx_din);
      end else begin
        check("tx_byte", {24'd0, tx_din}, {24'd0, exp_tx.pop_front()});
      end
      tx_pend = 1'b1;
    end else if (tx_pend) begin
      tx_pend = 1'b0;
      tx_busy = 1'b1;
      tx_left = TxLen;
    end else if (tx_busy) begin
      tx_left--;
      if (tx_left == 0) tx_busy = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    #1;
    check("rx_rdy_clr", {31'd0, rx_rdy_clr}, 32'd1);
    @(negedge clk);
    rx_rdy = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
    check("tx_busy_at_idle", {31'd0, tx_busy}, 32'd0);
  endtask

  task automatic clear_counts();
    we_cnt = 0;
    re_cnt = 0;
    wr_cnt = 0;
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    logic [7:0] rdata;
    int         kind;       // 0 reply only, 1 write, 2 read
    logic [7:0] reply;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int nrep;
    clear_counts();
    nrep = 1;
    bus_rdata = v.rdata;
    if (v.kind == 1) exp_bus.push_back({1'b1, v.cmd[3:0], v.data});
    if (v.kind == 2) exp_bus.push_back({1'b0, v.cmd[3:0], 8'h00});
    exp_tx.push_back(v.reply);
`ifdef UART_RSP_CHECKSUM_EN
    if (v.kind == 2) begin
      exp_tx.push_back(v.cmd ^ v.rdata);
      nrep = 2;
    end
`endif
    send_byte(v.cmd);
    if (v.kind == 1) begin
      send_byte(v.data);
`ifdef UART_RSP_CHECKSUM_EN
      send_byte(v.cmd ^ v.data);
`endif
    end
    wait_idle();
    check("we_count", we_cnt, (v.kind == 1) ? 1 : 0);
    check("re_count", re_cnt, (v.kind == 2) ? 1 : 0);
    check("wr_en_count", wr_cnt, nrep);
    check("queues_drained", exp_tx.size() + exp_bus.size(), 0);
  endtask

  function automatic logic [31:0] all_outs();
    return {12'd0, rx_rdy_clr, tx_din, tx_wr_en, bus_addr, bus_wdata, bus_we, bus_re,
            overrun, busy};
  endfunction

  vec_t vecs[8];

  initial begin
    vecs[0] = '{cmd: 8'h83, data: 8'hA5, rdata: 8'h00, kind: 1, reply: 8'h55};
    vecs[1] = '{cmd: 8'h07, data: 8'h00, rdata: 8'h3C, kind: 2, reply: 8'h3C};
    vecs[2] = '{cmd: 8'h90, data: 8'h00, rdata: 8'h00, kind: 0, reply: 8'hEE};
    vecs[3] = '{cmd: 8'h8F, data: 8'h00, rdata: 8'h00, kind: 1, reply: 8'h55};
    vecs[4] = '{cmd: 8'h00, data: 8'h00, rdata: 8'hFF, kind: 2, reply: 8'hFF};
    vecs[5] = '{cmd: 8'hF3, data: 8'h00, rdata: 8'h00, kind: 0, reply: 8'hEE};
    vecs[6] = '{cmd: 8'h81, data: 8'h10, rdata: 8'h00, kind: 1, reply: 8'h55};
    vecs[7] = '{cmd: 8'h4A, data: 8'h00, rdata: 8'h99, kind: 0, reply: 8'hEE};

    // Reset state.
    #25;
    check("reset_outputs", all_outs(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_outputs", all_outs(), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);
    check("no_overrun_yet", {31'd0, overrun}, 32'd0);

    // Timeout: write command then silence; no reply, then a normal read.
    clear_counts();
    send_byte(8'h81);
    repeat (49000) @(negedge clk);
    check("tmo_still_waiting", {31'd0, busy}, 32'd1);
    repeat (1100) @(negedge clk);
    check("tmo_back_idle", {31'd0, busy}, 32'd0);
    check("tmo_no_reply", wr_cnt + we_cnt, 0);
    run_vec('{cmd: 8'h02, data: 8'h00, rdata: 8'h5A, kind: 2, reply: 8'h5A});

`ifdef UART_RSP_CHECKSUM_EN
    // Bad checksum: NAK and no write.
    clear_counts();
    exp_tx.push_back(8'hEE);
    send_byte(8'h81);
    send_byte(8'h10);
    send_byte(8'h00);
    wait_idle();
    check("csum_bad_no_we", we_cnt, 0);
    check("csum_bad_one_reply", wr_cnt, 1);
`endif

    // Overrun: a byte arriving while the reply is being transmitted is dropped.
    clear_counts();
    bus_rdata = 8'h3C;
    exp_bus.push_back({1'b0, 4'h4, 8'h00});
    exp_tx.push_back(8'h3C);
`ifdef UART_RSP_CHECKSUM_EN
    exp_tx.push_back(8'h04 ^ 8'h3C);
`endif
    send_byte(8'h04);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_busy) break;
    end
    check("ovr_tx_busy_seen", {31'd0, tx_busy}, 32'd1);
    send_byte(8'h83);
    wait_idle();
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    check("ovr_no_we", we_cnt, 0);
`ifdef UART_RSP_CHECKSUM_EN
    check("ovr_reply_count", wr_cnt, 2);
`else
    check("ovr_reply_count", wr_cnt, 1);
`endif
    check("ovr_queues_drained", exp_tx.size() + exp_bus.size(), 0);

    // Reset in the middle of WAIT_DATA clears everything, including overrun.
    send_byte(8'h81);
    repeat (3) @(negedge clk);
    check("mid_frame_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_reset_outputs", all_outs(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec('{cmd: 8'h0A, data: 8'h00, rdata: 8'hC3, kind: 2, reply: 8'hC3});
    check("post_reset_no_overrun", {31'd0, overrun}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish, want finish before 5 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
